multi_ported_fifo_drain: RTL and testbench

Read-side consumer for the multi-ported FIFO. It issues contiguous low-order read requests across all FIFO read ports and collects the returned lanes into a small in-order buffer. It presents the words as a single valid/ready stream, one word per cycle. It sits between the multi-ported FIFO's read ports and any single-lane downstream consumer, with credit tracking so it never requests more data than it can hold.

---
 rtl/multi_ported_fifo_drain.sv | 140 ++++++++++++++
 tb/tb_multi_ported_fifo_drain.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multi_ported_fifo_drain.sv
// multi_ported_fifo_drain
//   Read-side consumer for a multi-ported FIFO. Each cycle it requests up to
//   NUM_READ_PORTS words on a contiguous run of read ports starting at port 0.
//   It captures the returned lanes into a small circular buffer and presents
//   them downstream as a single valid/ready stream, one word per cycle.
//   Requests are limited by a credit count, so the buffer can always absorb
//   every word that has been requested.
//
// Ports
//   clk, rst_n        clock, asynchronous active-low reset
//   enable            permits new read requests
//   fifo_rd_en        per-port read request (combinational, contiguous from port 0)
//   fifo_rd_data      returned lanes, lane i at [i*DATA_WIDTH +: DATA_WIDTH]
//   fifo_rd_valid     per-lane valid, one cycle after fifo_rd_en
//   fifo_data_count   FIFO occupancy
//   m_valid/m_data    output stream, m_data read straight from storage
//   m_ready           downstream accept
//   buf_count         buffer occupancy
//   err_overflow      sticky: a returned lane found no space
module multi_ported_fifo_drain #(
    parameter int DATA_WIDTH     = 32,
    parameter int NUM_READ_PORTS = 2,
    parameter int ADDR_WIDTH     = 4,
    parameter int BUF_DEPTH      = 4
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               enable,
    output logic [NUM_READ_PORTS-1:0]          fifo_rd_en,
    input  logic [NUM_READ_PORTS*DATA_WIDTH-1:0] fifo_rd_data,
    input  logic [NUM_READ_PORTS-1:0]          fifo_rd_valid,
    input  logic [ADDR_WIDTH:0]                fifo_data_count,
    output logic                               m_valid,
    output logic [DATA_WIDTH-1:0]              m_data,
    input  logic                               m_ready,
    output logic [$clog2(BUF_DEPTH):0]         buf_count,
    output logic                               err_overflow
);

    localparam int N  = NUM_READ_PORTS;
    localparam int PW = $clog2(BUF_DEPTH);
    localparam int CW = PW + 1;

    logic [DATA_WIDTH-1:0] buf_mem [BUF_DEPTH];
    logic [PW-1:0]         head;
    logic [PW-1:0]         tail;
    logic [CW-1:0]         count;
    logic [CW-1:0]         inflight;
    logic                  err_q;

    int                    free_slots;
    int                    req_cnt;
    int                    push_cnt;
    logic [N-1:0]          lane_wr;
    logic [PW-1:0]         lane_addr [N];
    logic                  lane_drop;
    logic                  pop;

    // Credit: requests issued last cycle are still on their way back, so they
    // are counted against free space. A pop this cycle is not credited until
    // count drops next cycle, which keeps m_ready off the request path.
    always_comb begin
        free_slots = BUF_DEPTH - int'(count) - int'(inflight);
        if (free_slots < 0) begin
            free_slots = 0;
        end
        req_cnt = N;
        if (int'(fifo_data_count) < req_cnt) begin
            req_cnt = int'(fifo_data_count);
        end
        if (free_slots < req_cnt) begin
            req_cnt = free_slots;
        end
        // Outputs must read zero while reset is held, even with enable high.
        if (!enable || !rst_n) begin
            req_cnt = 0;
        end
        for (int i = 0; i < N; i++) begin
            fifo_rd_en[i] = (i < req_cnt);
        end
    end

    // Returned lanes are packed in ascending lane order, so a sparse valid
    // pattern still fills consecutive slots. Space is judged on the occupancy
    // at the start of the cycle; a same-cycle pop does not make room.
    always_comb begin
        push_cnt  = 0;
        lane_wr   = '0;
        lane_drop = 1'b0;
        for (int i = 0; i < N; i++) begin
            lane_addr[i] = '0;
        end
        for (int i = 0; i < N; i++) begin
            if (fifo_rd_valid[i]) begin
                if (int'(count) + push_cnt < BUF_DEPTH) begin
                    lane_wr[i]   = 1'b1;
                    lane_addr[i] = tail + PW'(push_cnt);
                    push_cnt     = push_cnt + 1;
                end else begin
                    lane_drop = 1'b1;
                end
            end
        end
    end

    assign m_valid      = (count != '0);
    assign m_data       = buf_mem[head];
    assign pop          = m_valid && m_ready;
    assign buf_count    = count;
    assign err_overflow = err_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head     <= '0;
            tail     <= '0;
            count    <= '0;
            inflight <= '0;
            err_q    <= 1'b0;
            for (int i = 0; i < BUF_DEPTH; i++) begin
                buf_mem[i] <= '0;
            end
        end else begin
            for (int i = 0; i < N; i++) begin
                if (lane_wr[i]) begin
                    buf_mem[lane_addr[i]] <= fifo_rd_data[i*DATA_WIDTH +: DATA_WIDTH];
                end
            end
            tail     <= tail + PW'(push_cnt);
            if (pop) begin
                head <= head + PW'(1);
            end
            count    <= count + CW'(push_cnt) - CW'(pop);
            inflight <= CW'(req_cnt);
            if (lane_drop) begin
                err_q <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_multi_ported_fifo_drain.sv
// Testbench for multi_ported_fifo_drain with N=2, BUF_DEPTH=4.
// A behavioural FIFO (queue) answers the read ports. A queue-based reference
// buffer predicts the output stream, occupancy and error flag every cycle.
module tb_multi_ported_fifo_drain;

    localparam int DW = 32;
    localparam int N  = 2;
    localparam int AW = 4;
    localparam int BD = 4;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            enable;
    logic [N-1:0]    fifo_rd_en;
    logic [N*DW-1:0] fifo_rd_data;
    logic [N-1:0]    fifo_rd_valid;
    logic [AW:0]     fifo_data_count;
    logic            m_valid;
    logic [DW-1:0]   m_data;
    logic            m_ready;
    logic [2:0]      buf_count;
    logic            err_overflow;

    multi_ported_fifo_drain #(
        .DATA_WIDTH(DW), .NUM_READ_PORTS(N), .ADDR_WIDTH(AW), .BUF_DEPTH(BD)
    ) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable),
        .fifo_rd_en(fifo_rd_en), .fifo_rd_data(fifo_rd_data),
        .fifo_rd_valid(fifo_rd_valid), .fifo_data_count(fifo_data_count),
        .m_valid(m_valid), .m_data(m_data), .m_ready(m_ready),
        .buf_count(buf_count), .err_overflow(err_overflow)
    );

    always #5 clk = ~clk;

    int            checks = 0;
    int            errors = 0;
    logic [DW-1:0] fifo_q  [$];
    logic [DW-1:0] ref_buf [$];
    int            ref_inflight;
    bit            ref_err;
    int            pops_total;
    logic [N-1:0]  obs_en;
    logic          obs_valid;
    logic [DW-1:0] obs_data;
    logic [2:0]    obs_cnt;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive_count();
        fifo_data_count = 5'(fifo_q.size());
    endtask

    // Entered and left at posedge+1. Checks the DUT mid-cycle, then advances
    // the FIFO model and the reference buffer across the clock edge.
    task automatic cycle();
        int           free_s;
        int           k;
        logic [N-1:0] exp_en;
        logic [N-1:0] rd;
        bit           pop;
        drive_count();
        #2;
        free_s = BD - ref_buf.size() - ref_inflight;
        if (free_s < 0) free_s = 0;
        k = N;
        if (fifo_q.size() < k) k = fifo_q.size();
        if (free_s < k) k = free_s;
        if (!enable) k = 0;
        exp_en = '0;
        for (int i = 0; i < N; i++) if (i < k) exp_en[i] = 1'b1;
        obs_en    = fifo_rd_en;
        obs_valid = m_valid;
        obs_data  = m_data;
        obs_cnt   = buf_count;
        chk("rd_en", fifo_rd_en, exp_en);
        chk("m_valid", m_valid, ref_buf.size() != 0);
        if (ref_buf.size() != 0) chk("m_data", m_data, ref_buf[0]);
        chk("buf_count", buf_count, ref_buf.size());
        chk("err_overflow", err_overflow, ref_err);
        pop = (ref_buf.size() != 0) && m_ready;
        rd  = fifo_rd_en;
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) begin
            if (fifo_rd_valid[i]) begin
                if (ref_buf.size() < BD) ref_buf.push_back(fifo_rd_data[i*DW +: DW]);
                else ref_err = 1'b1;
            end
        end
        if (pop) begin
            void'(ref_buf.pop_front());
            pops_total++;
        end
        ref_inflight  = k;
        fifo_rd_valid = '0;
        fifo_rd_data  = '0;
        for (int i = 0; i < N; i++) begin
            if (rd[i] && fifo_q.size() > 0) begin
                fifo_rd_data[i*DW +: DW] = fifo_q.pop_front();
                fifo_rd_valid[i] = 1'b1;
            end
        end
        drive_count();
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_rd_en"}, fifo_rd_en, 0);
        chk({tag, "_m_valid"}, m_valid, 0);
        chk({tag, "_m_data"}, m_data, 0);
        chk({tag, "_buf_count"}, buf_count, 0);
        chk({tag, "_err"}, err_overflow, 0);
    endtask

    task automatic reset_dut();
        rst_n = 1'b0;
        fifo_q.delete();
        ref_buf.delete();
        ref_inflight = 0;
        ref_err = 1'b0;
        repeat (3) begin
            enable          = 1'($urandom);
            m_ready         = 1'($urandom);
            fifo_data_count = 5'($urandom);
            fifo_rd_valid   = 2'($urandom);
            fifo_rd_data    = {$urandom, $urandom};
            #2;
            chk_zero("rst");
            @(posedge clk);
            #1;
        end
        fifo_rd_valid = '0;
        fifo_rd_data  = '0;
        enable  = 1'b0;
        m_ready = 1'b0;
        drive_count();
        rst_n = 1'b1;
    endtask

    initial begin
        int first;
        int last;
        int n;
        int sent;
        int budget;
        rst_n = 1'b0; enable = 1'b0; m_ready = 1'b0;
        fifo_rd_valid = '0; fifo_rd_data = '0; fifo_data_count = '0;
        @(posedge clk);
        #1;
        reset_dut();

        // Single word: request, return, present, consume.
        fifo_q.push_back(32'hA5A50001);
        enable = 1'b1; m_ready = 1'b1;
        cycle(); chk("sw_c0_en", obs_en, 2'b01);
        cycle(); chk("sw_c1_valid", obs_valid, 0);
        cycle(); chk("sw_c2_valid", obs_valid, 1); chk("sw_c2_data", obs_data, 32'hA5A50001);
        cycle(); chk("sw_c3_valid", obs_valid, 0);

        // Burst of 8 with m_ready high: gapless from cycle 2.
        reset_dut();
        for (int w = 0; w < 8; w++) fifo_q.push_back(DW'(w));
        enable = 1'b1; m_ready = 1'b1;
        first = -1; last = -1; n = 0;
        for (int c = 0; c < 14; c++) begin
            cycle();
            if (c == 0) chk("burst_c0_en", obs_en, 2'b11);
            if (obs_valid) begin
                if (first < 0) first = c;
                last = c;
                chk("burst_data", obs_data, n);
                n++;
            end
        end
        chk("burst_first", first, 2);
        chk("burst_last", last, 9);
        chk("burst_words", n, 8);
        chk("burst_err", err_overflow, 0);

        // Backpressure: buffer fills to 4 and requests stop, then drains gapless.
        reset_dut();
        for (int w = 0; w < 10; w++) fifo_q.push_back(32'h100 + DW'(w));
        enable = 1'b1; m_ready = 1'b0;
        repeat (8) cycle();
        chk("bp_full", obs_cnt, 4);
        chk("bp_no_req", obs_en, 0);
        m_ready = 1'b1;
        first = -1; last = -1; n = 0;
        for (int c = 0; c < 20; c++) begin
            cycle();
            if (obs_valid) begin
                if (first < 0) first = c;
                last = c;
                chk("bp_data", obs_data, 32'h100 + n);
                n++;
            end
        end
        chk("bp_words", n, 10);
        chk("bp_span", last - first, 9);

        // Enable pause: one 2-wide request, then no more; both words still emerge.
        reset_dut();
        for (int w = 0; w < 6; w++) fifo_q.push_back(32'h200 + DW'(w));
        enable = 1'b1; m_ready = 1'b1;
        cycle(); chk("ep_c0_en", obs_en, 2'b11);
        enable = 1'b0; n = 0;
        for (int c = 0; c < 8; c++) begin
            cycle();
            chk("ep_en_off", obs_en, 0);
            if (obs_valid) begin
                chk("ep_data", obs_data, 32'h200 + n);
                n++;
            end
        end
        chk("ep_words", n, 2);

        // Asynchronous reset mid-burst clears outputs before any clock edge.
        reset_dut();
        for (int w = 0; w < 8; w++) fifo_q.push_back(32'h300 + DW'(w));
        enable = 1'b1; m_ready = 1'b1;
        repeat (3) cycle();
        #2;
        chk("async_pre_valid", m_valid, 1);
        rst_n = 1'b0;
        #1;
        chk_zero("async");
        @(posedge clk);
        #1;
        reset_dut();

        // Overflow injection: full buffer plus two unsolicited lanes.
        for (int w = 0; w < 4; w++) fifo_q.push_back(32'h400 + DW'(w));
        enable = 1'b1; m_ready = 1'b0;
        repeat (5) cycle();
        chk("ovf_pre_full", obs_cnt, 4);
        enable = 1'b0;
        fifo_rd_valid = 2'b11;
        fifo_rd_data  = {32'hDEAD0001, 32'hDEAD0000};
        cycle();
        repeat (3) cycle();
        chk("ovf_flag", obs_en, 0);
        chk("ovf_err", err_overflow, 1);
        chk("ovf_cnt", buf_count, 4);
        m_ready = 1'b1;
        n = 0;
        for (int c = 0; c < 6; c++) begin
            cycle();
            if (obs_valid) begin
                chk("ovf_data", obs_data, 32'h400 + n);
                n++;
            end
        end
        chk("ovf_words", n, 4);
        chk("ovf_sticky", err_overflow, 1);
        reset_dut();
        #2;
        chk("ovf_cleared", err_overflow, 0);
        @(posedge clk);
        #1;

        // Random traffic against the reference model.
        pops_total = 0; sent = 0;
        for (int c = 0; c < 400; c++) begin
            if ($urandom_range(0, 3) != 0) begin
                repeat ($urandom_range(1, 2)) begin
                    if (fifo_q.size() < 30) begin
                        fifo_q.push_back($urandom);
                        sent++;
                    end
                end
            end
            enable  = ($urandom_range(0, 9) != 0);
            m_ready = ($urandom_range(0, 9) < 7);
            cycle();
        end
        enable = 1'b1; m_ready = 1'b1;
        budget = 0;
        while ((fifo_q.size() != 0 || ref_buf.size() != 0 || ref_inflight != 0
                || fifo_rd_valid != '0) && budget < 100) begin
            cycle();
            budget++;
        end
        chk("rand_drained", fifo_q.size() + ref_buf.size(), 0);
        chk("rand_words", pops_total, sent);
        chk("rand_err", err_overflow, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
